e_mdu: RTL and testbench

Multiply/divide unit in the Execute stage of the five-stage MIPS pipeline. Its operands are the forwarded register-file read values (rs/rt) carried through the D/E pipeline register. It executes mult, multu, div and divu over a fixed multi-cycle latency, and handles mthi and mtlo. It holds the HI/LO architectural registers, and it exports a busy flag that the hazard unit uses to stall later MDU instructions in Decode.

---
 rtl/e_mdu.sv | 140 ++++++++++++++
 tb/tb_e_mdu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// MIPS Execute-stage multiply/divide unit: HI/LO registers, fixed-latency
// mult/multu/div/divu on latched operands, plus single-cycle mthi/mtlo.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [31:0]        r_a, w_a_nx;
  logic [31:0]        r_b, w_b_nx;
  logic [2:0]         r_op, w_op_nx;
  logic [31:0]        r_hi, w_hi_nx;
  logic [31:0]        r_lo, w_lo_nx;
  logic [63:0]        w_mul;
  logic [63:0]        w_div;

  // The low 64 bits of the product of sign/zero-extended operands give both forms.
  function automatic logic [63:0] f_mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Magnitude division avoids the signed 0x80000000 / -1 overflow; returns {rem, quot}.
  function automatic logic [63:0] f_div(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31])           r = -r;
    return {r, q};
  endfunction

  assign w_mul = f_mul(r_a, r_b, r_op == OP_MULT);
  assign w_div = f_div(r_a, r_b, r_op == OP_DIV);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              w_a_nx     = A;
              w_b_nx     = B;
              w_op_nx    = op;
              w_cnt_nx   = CNT_W'(MULT_CYCLES);
              w_state_nx = RUN;
            end
            OP_DIV, OP_DIVU: begin
              w_a_nx     = A;
              w_b_nx     = B;
              w_op_nx    = op;
              w_cnt_nx   = CNT_W'(DIV_CYCLES);
              w_state_nx = RUN;
            end
            OP_MTHI: w_hi_nx = A;
            OP_MTLO: w_lo_nx = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; the hazard unit keeps it off while busy.
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nx = IDLE;
          case (r_op)
            OP_MULT, OP_MULTU: {w_hi_nx, w_lo_nx} = w_mul;
            OP_DIV, OP_DIVU: begin
              if (r_b != 32'd0) {w_hi_nx, w_lo_nx} = w_div;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
    end
  end

  assign busy = (r_state == RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: cycle-accurate reference model checked every cycle,
// plus hand-computed literal results for each directed vector.
module tb_e_mdu;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  e_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural results from plain integer arithmetic,
  // committed at an absolute edge number accept+N.
  longint      m_edge = 0;
  longint      m_due  = 0;
  logic        m_busy;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_wr;

  function automatic void model_res(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b, output logic wr,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sp;
    longint unsigned up;
    int sa, sb;
    wr = 1'b1; hi = 0; lo = 0;
    case (o)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      3'd2: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 0;
        end else begin
          sa = $signed(a); sb = $signed(b);
          lo = sa / sb; hi = sa % sb;
        end
      end
      3'd4: begin
        if (b == 0) wr = 1'b0;
        else begin lo = a / b; hi = a % b; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_hi = 0; m_lo = 0;
    end else begin
      m_edge++;
      if (m_busy) begin
        if (m_edge == m_due) begin
          m_busy = 1'b0;
          if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (start) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          model_res(op, A, B, p_wr, p_hi, p_lo);
          m_due  = m_edge + ((op <= 3'd2) ? NM : ND);
          m_busy = 1'b1;
        end else if (op == 3'd5) m_hi = A;
        else if (op == 3'd6) m_lo = A;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_busy", {31'b0, busy}, {31'b0, m_busy});
      check("model_HI", HI, m_hi);
      check("model_LO", LO, m_lo);
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_idle(n);
    check({name, "_cycles"}, 32'(n), 32'(ncyc));
    check({name, "_HI"}, HI, ehi);
    check({name, "_LO"}, LO, elo);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; A = 0; B = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_HI", HI, 32'h1234_5678);
    check("mthi_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-cycle, observed before the next rising edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_HI", HI, 32'd0);
    check("arst_LO", LO, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, NM, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd5, 32'hAAAA_0000, 32'd0);
    issue(3'd6, 32'h0000_5555, 32'd0);
    run_op("divu0", 3'd4, 32'd7, 32'd0, ND, 32'hAAAA_0000, 32'h0000_5555);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000);
    run_op("divu",  3'd4, 32'd100, 32'd7, ND, 32'd2, 32'd14);
    run_op("divneg", 3'd3, 32'd7, 32'hFFFF_FFFE, ND, 32'd1, 32'hFFFF_FFFD);
    run_op("multbig", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NM, 32'hFFFF_FFFE, 32'h0000_0001);

    // Operand changes and a stray MTLO while running must not disturb the result.
    issue(3'd1, 32'd3, 32'd4);
    start = 1'b1; op = 3'd6; A = 32'd99; B = 32'd77;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    wait_idle(n);
    check("midrun_cycles", 32'(n), 32'(NM - 1));
    check("midrun_HI", HI, 32'd0);
    check("midrun_LO", LO, 32'd12);
    issue(3'd5, 32'h0000_DEAD, 32'd0);
    check("b2b_mthi_HI", HI, 32'h0000_DEAD);
    check("b2b_mthi_busy", {31'b0, busy}, 32'd0);

    // Reset during RUN discards the operation entirely.
    issue(3'd1, 32'd5, 32'd6);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstrun_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NM + 3) @(negedge clk);
    check("rstrun_HI", HI, 32'd0);
    check("rstrun_LO", LO, 32'd0);
    check("rstrun_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
